setup_hold_monitor: RTL and testbench

//  Synthesizable run-time checker for $setup/$hold/$setuphold-style timing checks.

---
 rtl/setup_hold_monitor.sv | 200 ++++++++++++++++++++
 tb/tb_setup_hold_monitor.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/setup_hold_monitor.sv
// setup_hold_monitor: run-time setup/hold window checker.
// An asynchronous reference clock, data and check enable are oversampled on clk,
// synchronized, edge-detected and judged against SETUP_TICKS / HOLD_TICKS.
// Build option: define TCHK_DELAYED_EN to add DELAY_TICKS-deep delay lines on
// delayed_ref / delayed_data; otherwise they carry the synchronized signals.
module setup_hold_monitor #(
    parameter int SETUP_TICKS = 4,
    parameter int HOLD_TICKS  = 2,
    parameter int CNT_W       = 16,
    parameter int DELAY_TICKS = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ref_in,
    input  logic             data_in,
    input  logic             cond_in,
    input  logic             clr_cnt,
    output logic             setup_viol,
    output logic             hold_viol,
    output logic             notifier,
    output logic [CNT_W-1:0] setup_cnt,
    output logic [CNT_W-1:0] hold_cnt,
    output logic             delayed_ref,
    output logic             delayed_data
);

    localparam logic [7:0] SETUP_L = 8'(SETUP_TICKS);
    localparam logic [7:0] HOLD_M1 = 8'(HOLD_TICKS - 1);
    localparam bit         HOLD_EN = (HOLD_TICKS > 0);

    // Hold window state; IDLE = no window open, HOLD = counting after a qualifying ref edge.
    typedef enum logic {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    logic   r_ref_s1, r_ref_s2, r_ref_q;
    logic   r_data_s1, r_data_s2, r_data_q;
    logic   r_cond_s1, r_cond_s2;
    logic   [7:0] r_since;
    logic   r_seen;
    state_t r_state;
    logic   [7:0] r_hold_ctr;

    logic   w_ref_rise, w_data_edge, w_qual_rise, w_seen;
    logic   [7:0] w_since;
    logic   w_setup_det, w_hold_det;
    state_t w_state_nxt;
    logic   [7:0] w_hold_ctr_nxt;

    // Two-flop synchronizers plus one edge register for ref and data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ref_s1  <= 1'b0;
            r_ref_s2  <= 1'b0;
            r_ref_q   <= 1'b0;
            r_data_s1 <= 1'b0;
            r_data_s2 <= 1'b0;
            r_data_q  <= 1'b0;
            r_cond_s1 <= 1'b0;
            r_cond_s2 <= 1'b0;
        end else begin
            r_ref_s1  <= ref_in;
            r_ref_s2  <= r_ref_s1;
            r_ref_q   <= r_ref_s2;
            r_data_s1 <= data_in;
            r_data_s2 <= r_data_s1;
            r_data_q  <= r_data_s2;
            r_cond_s1 <= cond_in;
            r_cond_s2 <= r_cond_s1;
        end
    end

    assign w_ref_rise  = r_ref_s2 & ~r_ref_q;
    assign w_data_edge = r_data_s2 ^ r_data_q;
    // cond is taken from the same stage as ref so both refer to the same sample.
    assign w_qual_rise = w_ref_rise & r_cond_s2;

    // Distance (in clk) from the latest data edge to the current cycle, saturating.
    always_comb begin
        w_since = r_since;
        if (w_data_edge)
            w_since = 8'd0;
        else if (r_since >= SETUP_L)
            w_since = SETUP_L;
        else
            w_since = r_since + 8'd1;
    end

    // A data edge in the ref_rise cycle itself counts as distance 0.
    assign w_seen      = r_seen | w_data_edge;
    assign w_setup_det = w_qual_rise & w_seen & (w_since < SETUP_L);

    // Distance tracker and first-edge flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_since <= 8'd0;
            r_seen  <= 1'b0;
        end else begin
            r_since <= w_since;
            r_seen  <= w_seen;
        end
    end

    // Hold FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_hold_ctr <= 8'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_hold_ctr <= w_hold_ctr_nxt;
        end
    end

    // Hold FSM next state: a new qualifying edge restarts the window and wins over
    // a same-cycle data edge; otherwise the first data edge flags and closes it.
    always_comb begin
        w_state_nxt    = r_state;
        w_hold_ctr_nxt = r_hold_ctr;
        w_hold_det     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_qual_rise && HOLD_EN) begin
                    w_state_nxt    = S_HOLD;
                    w_hold_ctr_nxt = 8'd0;
                end
            end
            S_HOLD: begin
                if (w_qual_rise) begin
                    w_hold_ctr_nxt = 8'd0;
                end else if (w_data_edge) begin
                    w_hold_det  = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (r_hold_ctr == HOLD_M1) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_hold_ctr_nxt = r_hold_ctr + 8'd1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Registered violation pulses; notifier toggles once per cycle with any violation.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            setup_viol <= 1'b0;
            hold_viol  <= 1'b0;
            notifier   <= 1'b0;
        end else begin
            setup_viol <= w_setup_det;
            hold_viol  <= w_hold_det;
            notifier   <= notifier ^ (w_setup_det | w_hold_det);
        end
    end

    // Saturating counters fed by the pulses; clr_cnt wins over an increment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            setup_cnt <= '0;
            hold_cnt  <= '0;
        end else if (clr_cnt) begin
            setup_cnt <= '0;
            hold_cnt  <= '0;
        end else begin
            if (setup_viol && (setup_cnt != {CNT_W{1'b1}}))
                setup_cnt <= setup_cnt + 1'b1;
            if (hold_viol && (hold_cnt != {CNT_W{1'b1}}))
                hold_cnt <= hold_cnt + 1'b1;
        end
    end

`ifdef TCHK_DELAYED_EN
    logic [DELAY_TICKS-1:0] r_dly_ref;
    logic [DELAY_TICKS-1:0] r_dly_data;

    // Delay lines behind the synchronizers, DELAY_TICKS stages deep.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dly_ref  <= '0;
            r_dly_data <= '0;
        end else begin
            r_dly_ref[0]  <= r_ref_s2;
            r_dly_data[0] <= r_data_s2;
            for (int i = 1; i < DELAY_TICKS; i++) begin
                r_dly_ref[i]  <= r_dly_ref[i-1];
                r_dly_data[i] <= r_dly_data[i-1];
            end
        end
    end

    assign delayed_ref  = r_dly_ref[DELAY_TICKS-1];
    assign delayed_data = r_dly_data[DELAY_TICKS-1];
`else
    assign delayed_ref  = r_ref_s2;
    assign delayed_data = r_data_s2;
`endif

endmodule

// File: tb/tb_setup_hold_monitor.sv
// tb_setup_hold_monitor: directed scenarios followed by random traffic, checked
// against a window model expressed in input-cycle indices.
module tb_setup_hold_monitor;

    localparam int SETUP = 4;
    localparam int HOLD  = 2;
    localparam int CW    = 2;
    localparam int DT    = 3;
    localparam int MAXC  = (1 << CW) - 1;
`ifdef TCHK_DELAYED_EN
    localparam int DLY = DT;
`else
    localparam int DLY = 0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ref_in = 1'b0, data_in = 1'b0, cond_in = 1'b0, clr_cnt = 1'b0;
    logic          setup_viol, hold_viol, notifier, delayed_ref, delayed_data;
    logic [CW-1:0] setup_cnt, hold_cnt;

    always #5 clk = ~clk;

    setup_hold_monitor #(
        .SETUP_TICKS(SETUP), .HOLD_TICKS(HOLD), .CNT_W(CW), .DELAY_TICKS(DT)
    ) dut (
        .clk(clk), .rst(rst), .ref_in(ref_in), .data_in(data_in), .cond_in(cond_in),
        .clr_cnt(clr_cnt), .setup_viol(setup_viol), .hold_viol(hold_viol),
        .notifier(notifier), .setup_cnt(setup_cnt), .hold_cnt(hold_cnt),
        .delayed_ref(delayed_ref), .delayed_data(delayed_data)
    );

    typedef struct packed { bit s; bit h; } det_t;

    int   n_vec = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   base = 0;
    bit   h_ref[0:4095];
    bit   h_data[0:4095];
    // model: windows described by cycle indices of the relevant edges
    int   last_data, last_qual;
    bit   seen, win_open, win_viol;
    det_t pipe_q[$];
    bit   m_not, prev_s, prev_h;
    int   m_scnt, m_hcnt;

    function automatic bit get_ref(int i);
        return (i < base) ? 1'b0 : h_ref[i];
    endfunction

    function automatic bit get_data(int i);
        return (i < base) ? 1'b0 : h_data[i];
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_clear();
        seen = 0; win_open = 0; win_viol = 0; last_data = 0; last_qual = 0;
        pipe_q.delete();
        pipe_q.push_back('0);
        pipe_q.push_back('0);
        m_not = 0; prev_s = 0; prev_h = 0; m_scnt = 0; m_hcnt = 0;
    endtask

    // One clk of stimulus, then check the outputs of the following cycle.
    task automatic step(bit r, bit d, bit c, bit clr);
        det_t e;
        bit   rise, de, qual;
        ref_in = r; data_in = d; cond_in = c; clr_cnt = clr;
        h_ref[cyc] = r; h_data[cyc] = d;
        rise = r && !get_ref(cyc - 1);
        de   = (d != get_data(cyc - 1));
        qual = rise && c;
        e    = '0;
        if (de) begin last_data = cyc; seen = 1; end
        if (qual && seen && (cyc - last_data) < SETUP) e.s = 1;
        if (de && !qual && win_open && !win_viol &&
            (cyc - last_qual) >= 1 && (cyc - last_qual) <= HOLD) begin
            e.h = 1; win_viol = 1;
        end
        if (qual) begin last_qual = cyc; win_open = 1; win_viol = 0; end
        pipe_q.push_back(e);
        @(posedge clk); #1;
        if (clr) begin
            m_scnt = 0; m_hcnt = 0;
        end else begin
            if (prev_s && m_scnt < MAXC) m_scnt++;
            if (prev_h && m_hcnt < MAXC) m_hcnt++;
        end
        e = pipe_q.pop_front();
        if (e.s || e.h) m_not = ~m_not;
        prev_s = e.s; prev_h = e.h;
        check("setup_viol", 32'(setup_viol), 32'(e.s));
        check("hold_viol", 32'(hold_viol), 32'(e.h));
        check("notifier", 32'(notifier), 32'(m_not));
        check("setup_cnt", 32'(setup_cnt), 32'(m_scnt));
        check("hold_cnt", 32'(hold_cnt), 32'(m_hcnt));
        check("delayed_ref", 32'(delayed_ref), 32'(get_ref(cyc - 1 - DLY)));
        check("delayed_data", 32'(delayed_data), 32'(get_data(cyc - 1 - DLY)));
        cyc++;
    endtask

    task automatic do_reset(int n_hold);
        ref_in = 0; data_in = 0; cond_in = 0; clr_cnt = 0;
        rst = 0;
        #1;
        check("rst_setup_viol", 32'(setup_viol), 32'd0);
        check("rst_hold_viol", 32'(hold_viol), 32'd0);
        check("rst_notifier", 32'(notifier), 32'd0);
        check("rst_setup_cnt", 32'(setup_cnt), 32'd0);
        check("rst_hold_cnt", 32'(hold_cnt), 32'd0);
        check("rst_delayed_ref", 32'(delayed_ref), 32'd0);
        check("rst_delayed_data", 32'(delayed_data), 32'd0);
        repeat (n_hold) @(posedge clk);
        #1;
        rst = 1;
        base = cyc;
        model_clear();
    endtask

    initial begin
        bit r, d, c, clr;
        model_clear();
        #2;
        do_reset(3);

        // 1: data edge, ref 6 clk later -> clean
        step(0, 1, 1, 0);
        repeat (5) step(0, 1, 1, 0);
        step(1, 1, 1, 0);
        repeat (6) step(0, 1, 1, 0);

        // 2: data edge, ref 2 clk later -> setup violation
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        step(1, 0, 1, 0);
        repeat (6) step(0, 0, 1, 0);

        // 3: ref rise, data 1 clk later -> hold violation; second toggle ignored
        step(1, 0, 1, 0);
        step(1, 1, 1, 0);
        step(1, 0, 1, 0);
        repeat (6) step(0, 0, 1, 0);

        // 4: scenario 2 with cond=0 -> nothing
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        step(1, 1, 0, 0);
        repeat (6) step(0, 1, 0, 0);
        // open window with cond=1, then unqualified ref edge with a data edge inside it
        step(1, 1, 1, 0);
        step(0, 1, 0, 0);
        step(1, 0, 0, 0);
        repeat (6) step(0, 0, 1, 0);

        // 5: five setup violations saturate the 2-bit counter
        d = 0;
        for (int k = 0; k < 5; k++) begin
            d = ~d;
            step(0, d, 1, 0);
            step(1, d, 1, 0);
            repeat (4) step(0, d, 1, 0);
        end
        repeat (3) step(0, d, 1, 0);
        // clr_cnt in the cycle the pulse is high: counter cleared, notifier still toggles
        d = ~d;
        step(0, d, 1, 0);
        step(1, d, 1, 0);
        step(0, d, 1, 0);
        step(0, d, 1, 0);
        step(0, d, 1, 1);
        repeat (4) step(0, d, 1, 0);

        // 6: delayed copies track a lone ref toggle; reset inside an open hold window
        step(1, d, 0, 0);
        repeat (7) step(1, d, 0, 0);
        repeat (7) step(0, d, 1, 0);
        step(1, d, 1, 0);
        step(1, ~d, 1, 0);
        step(1, ~d, 1, 0);
        do_reset(2);
        repeat (2) step(0, 1, 1, 0);
        repeat (6) step(0, 0, 1, 0);

        // random traffic
        r = 0; d = 0;
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 2) == 0) r = ~r;
            if ($urandom_range(0, 3) == 0) d = ~d;
            c   = ($urandom_range(0, 4) != 0);
            clr = ($urandom_range(0, 19) == 0);
            step(r, d, c, clr);
            if (k == 200) do_reset($urandom_range(1, 3));
        end
        repeat (8) step(0, d, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
